// File: rtl/ff_pkg.sv
// ---------------------------------------------------------------------------
// ff_pkg
// Shared definitions for the multi-mode flip-flop bank.
//   ff_mode_e : run-time next-state rule (D, T, JK, SR)
//   ff_next_t : result of one bit's next-state evaluation
//   ff_next() : per-bit next-state function, also flags S=R=1
// ---------------------------------------------------------------------------
package ff_pkg;

    typedef enum logic [1:0] {
        FF_D  = 2'd0,
        FF_T  = 2'd1,
        FF_JK = 2'd2,
        FF_SR = 2'd3
    } ff_mode_e;

    typedef struct packed {
        logic nxt;
        logic illegal;
    } ff_next_t;

    // Illegal SR inputs return the current state, so a caller that simply
    // loads nxt gets the required "hold" behaviour without a special case.
    function automatic ff_next_t ff_next(input ff_mode_e mode, input logic q,
                                         input logic a, input logic b);
        ff_next_t r;
        r.nxt     = q;
        r.illegal = 1'b0;
        case (mode)
            FF_D:  r.nxt = a;
            FF_T:  r.nxt = q ^ a;
            FF_JK: begin
                case ({a, b})
                    2'b01:   r.nxt = 1'b0;
                    2'b10:   r.nxt = 1'b1;
                    2'b11:   r.nxt = ~q;
                    default: r.nxt = q;
                endcase
            end
            FF_SR: begin
                case ({a, b})
                    2'b01:   r.nxt = 1'b0;
                    2'b10:   r.nxt = 1'b1;
                    2'b11:   r.illegal = 1'b1;
                    default: r.nxt = q;
                endcase
            end
            default: r.nxt = q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/multi_mode_ff_bank_if.sv
// ---------------------------------------------------------------------------
// multi_mode_ff_bank_if
// Bus bundle for the flip-flop bank.
//   master drives : en, mode, a, b, clr_err
//   slave drives  : q, qbar, sr_err, err_cnt
// ---------------------------------------------------------------------------
interface multi_mode_ff_bank_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    import ff_pkg::*;

    logic               en;
    ff_mode_e           mode;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               clr_err;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   qbar;
    logic [WIDTH-1:0]   sr_err;
    logic [CNT_W-1:0]   err_cnt;

    modport master (
        output en, mode, a, b, clr_err,
        input  q, qbar, sr_err, err_cnt
    );

    modport slave (
        input  en, mode, a, b, clr_err,
        output q, qbar, sr_err, err_cnt
    );

endinterface

// File: rtl/ff_cell.sv
// ---------------------------------------------------------------------------
// ff_cell
// One bit of the bank: mode mux plus state register.
//   clk, rst    : clock and synchronous active-high reset
//   en          : clock enable, q holds when low
//   mode        : next-state rule shared by the whole bank
//   a, b        : d/t/j/s and k/r inputs for this bit
//   q           : registered state
//   illegal     : S=R=1 seen on this bit while enabled in SR mode
// ---------------------------------------------------------------------------
module ff_cell
    import ff_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    input  ff_mode_e mode,
    input  logic     a,
    input  logic     b,
    output logic     q,
    output logic     illegal
);

    ff_next_t step;

    // Next-state evaluation from the current q; illegal is qualified by en
    // so a disabled bank never reports errors.
    always_comb begin
        step    = ff_next(mode, q, a, b);
        illegal = en & step.illegal;
    end

    // State register; reset beats enable, and an illegal SR step already
    // carries the current state so loading it holds the bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_BIT;
        end else if (en) begin
            q <= step.nxt;
        end
    end

endmodule

// File: rtl/multi_mode_ff_bank.sv
// ---------------------------------------------------------------------------
// multi_mode_ff_bank
// WIDTH flip-flops with a run-time selectable D/T/JK/SR rule, clock enable,
// reset value and illegal-SR detection.
//   clk, rst : clock and synchronous active-high reset (highest priority)
//   bus      : slave side of multi_mode_ff_bank_if
//              in  en, mode, a, b, clr_err
//              out q, qbar (= ~q), sr_err (sticky per bit),
//                  err_cnt (saturating count of cycles with any illegal bit)
// ---------------------------------------------------------------------------
module multi_mode_ff_bank
    import ff_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    multi_mode_ff_bank_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] illegal_mask;
    logic [WIDTH-1:0] sr_err_reg;
    logic [CNT_W-1:0] err_cnt_reg;
    logic             any_illegal;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ff_cell #(
            .RESET_BIT (RESET_VAL[i])
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .en      (bus.en),
            .mode    (bus.mode),
            .a       (bus.a[i]),
            .b       (bus.b[i]),
            .q       (q_reg[i]),
            .illegal (illegal_mask[i])
        );
    end

    assign any_illegal = |illegal_mask;

    // Error bookkeeping. A clear in the same cycle as a new illegal event
    // restarts the history from that event rather than discarding it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_err_reg  <= '0;
            err_cnt_reg <= '0;
        end else if (bus.clr_err) begin
            sr_err_reg  <= illegal_mask;
            err_cnt_reg <= any_illegal ? CNT_W'(1) : '0;
        end else begin
            sr_err_reg <= sr_err_reg | illegal_mask;
            if (any_illegal && err_cnt_reg != CNT_MAX) begin
                err_cnt_reg <= err_cnt_reg + 1'b1;
            end
        end
    end

    assign bus.q       = q_reg;
    assign bus.qbar    = ~q_reg;
    assign bus.sr_err  = sr_err_reg;
    assign bus.err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// ---------------------------------------------------------------------------
// tb_multi_mode_ff_bank
// Directed vector table for the documented scenarios, then randomized
// traffic compared against a word-level behavioural model.
// ---------------------------------------------------------------------------
module tb_multi_mode_ff_bank;
    import ff_pkg::*;

    localparam int         WIDTH     = 8;
    localparam int         CNT_W     = 2;
    localparam logic [7:0] RESET_VAL = 8'hA5;
    localparam int         CNT_SAT   = (1 << CNT_W) - 1;

    typedef struct {
        string      name;
        bit         rst;
        bit         en;
        bit [1:0]   mode;
        bit [7:0]   a;
        bit [7:0]   b;
        bit         clr;
        bit [7:0]   exp_q;
        bit [7:0]   exp_err;
        int         exp_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];

    bit [7:0] mq;
    bit [7:0] merr;
    int       mcnt;

    multi_mode_ff_bank_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus();

    multi_mode_ff_bank #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL),
        .CNT_W     (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Drive one cycle of inputs on the falling edge, let the rising edge
    // take them, and return shortly after that edge for sampling.
    task automatic applyStimulus(input bit r, input bit e, input bit [1:0] m,
                                 input bit [7:0] av, input bit [7:0] bv,
                                 input bit c);
        @(negedge clk);
        rst         = r;
        bus.en      = e;
        bus.mode    = ff_mode_e'(m);
        bus.a       = av;
        bus.b       = bv;
        bus.clr_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input bit [7:0] eq,
                               input bit [7:0] eerr, input int ecnt);
        checks++;
        if (bus.q !== eq) begin
            errors++;
            $display("[TB] FAIL %s q: got %h expected %h", name, bus.q, eq);
        end
        checks++;
        if (bus.qbar !== ~eq) begin
            errors++;
            $display("[TB] FAIL %s qbar: got %h expected %h", name, bus.qbar, ~eq);
        end
        checks++;
        if (bus.sr_err !== eerr) begin
            errors++;
            $display("[TB] FAIL %s sr_err: got %h expected %h", name, bus.sr_err, eerr);
        end
        checks++;
        if (bus.err_cnt !== CNT_W'(ecnt)) begin
            errors++;
            $display("[TB] FAIL %s err_cnt: got %0d expected %0d", name, bus.err_cnt, ecnt);
        end
    endtask

    // Word-level reference: JK and SR use their characteristic equations
    // across the whole byte; the counter is a plain saturating integer.
    task automatic modelStep(input bit r, input bit e, input bit [1:0] m,
                             input bit [7:0] av, input bit [7:0] bv,
                             input bit c);
        bit [7:0] ill;
        ill = 8'h00;
        if (r) begin
            mq   = RESET_VAL;
            merr = 8'h00;
            mcnt = 0;
        end else begin
            if (e) begin
                case (m)
                    2'd0: mq = av;
                    2'd1: mq = mq ^ av;
                    2'd2: mq = (av & ~mq) | (~bv & mq);
                    default: begin
                        ill = av & bv;
                        mq  = (av & ~bv) | (mq & ~(bv & ~av));
                    end
                endcase
            end
            if (c) begin
                merr = ill;
                mcnt = (ill != 0) ? 1 : 0;
            end else begin
                merr = merr | ill;
                if (ill != 0 && mcnt < CNT_SAT) mcnt = mcnt + 1;
            end
        end
    endtask

    initial begin
        bus.en      = 1'b0;
        bus.mode    = FF_D;
        bus.a       = '0;
        bus.b       = '0;
        bus.clr_err = 1'b0;

        //                 name           rst en mode a      b      clr  q      err    cnt
        vecs.push_back('{"reset",         1, 1, 2'd1, 8'hFF, 8'hFF, 1, 8'hA5, 8'h00, 0});
        vecs.push_back('{"d_load",        0, 1, 2'd0, 8'h3C, 8'h00, 0, 8'h3C, 8'h00, 0});
        vecs.push_back('{"t_toggle1",     0, 1, 2'd1, 8'hFF, 8'h00, 0, 8'hC3, 8'h00, 0});
        vecs.push_back('{"t_toggle2",     0, 1, 2'd1, 8'hFF, 8'h00, 0, 8'h3C, 8'h00, 0});
        vecs.push_back('{"en_low_hold",   0, 0, 2'd1, 8'hFF, 8'h00, 0, 8'h3C, 8'h00, 0});
        vecs.push_back('{"d_preload",     0, 1, 2'd0, 8'h0F, 8'h00, 0, 8'h0F, 8'h00, 0});
        vecs.push_back('{"jk_all",        0, 1, 2'd2, 8'hF0, 8'h3C, 0, 8'hF3, 8'h00, 0});
        vecs.push_back('{"d_preload2",    0, 1, 2'd0, 8'h0F, 8'h00, 0, 8'h0F, 8'h00, 0});
        vecs.push_back('{"sr_illegal1",   0, 1, 2'd3, 8'h11, 8'h01, 0, 8'h1F, 8'h01, 1});
        vecs.push_back('{"sr_illegal2",   0, 1, 2'd3, 8'h80, 8'h80, 0, 8'h1F, 8'h81, 2});
        vecs.push_back('{"sr_illegal3",   0, 1, 2'd3, 8'h04, 8'h04, 0, 8'h1F, 8'h85, 3});
        vecs.push_back('{"clr_only1",     0, 0, 2'd3, 8'h00, 8'h00, 1, 8'h1F, 8'h00, 0});
        vecs.push_back('{"sat_1",         0, 1, 2'd3, 8'h04, 8'h04, 0, 8'h1F, 8'h04, 1});
        vecs.push_back('{"sat_2",         0, 1, 2'd3, 8'h04, 8'h04, 0, 8'h1F, 8'h04, 2});
        vecs.push_back('{"sat_3",         0, 1, 2'd3, 8'h04, 8'h04, 0, 8'h1F, 8'h04, 3});
        vecs.push_back('{"sat_4",         0, 1, 2'd3, 8'h04, 8'h04, 0, 8'h1F, 8'h04, 3});
        vecs.push_back('{"sat_5",         0, 1, 2'd3, 8'h04, 8'h04, 0, 8'h1F, 8'h04, 3});
        vecs.push_back('{"clr_only2",     0, 0, 2'd0, 8'h00, 8'h00, 1, 8'h1F, 8'h00, 0});
        vecs.push_back('{"clr_and_ill",   0, 1, 2'd3, 8'h04, 8'h04, 1, 8'h1F, 8'h04, 1});
        vecs.push_back('{"en_low_no_det", 0, 0, 2'd3, 8'hFF, 8'hFF, 0, 8'h1F, 8'h04, 1});
        vecs.push_back('{"sr_set_legal",  0, 1, 2'd3, 8'h20, 8'h00, 0, 8'h3F, 8'h04, 1});
        vecs.push_back('{"rst_over_sr",   1, 1, 2'd3, 8'hFF, 8'hFF, 0, 8'hA5, 8'h00, 0});
        vecs.push_back('{"t_after_rst",   0, 1, 2'd1, 8'hFF, 8'h00, 0, 8'h5A, 8'h00, 0});
        vecs.push_back('{"rst_over_t",    1, 1, 2'd1, 8'hFF, 8'h00, 1, 8'hA5, 8'h00, 0});

        $display("[TB] directed table: %0d vectors", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].mode,
                          vecs[i].a, vecs[i].b, vecs[i].clr);
            checkOutput(vecs[i].name, vecs[i].exp_q, vecs[i].exp_err, vecs[i].exp_cnt);
        end

        $display("[TB] randomized phase");
        for (int i = 0; i < 400; i++) begin
            bit       r;
            bit       e;
            bit [1:0] m;
            bit [7:0] av;
            bit [7:0] bv;
            bit       c;
            r  = (i == 0) || ($urandom_range(0, 31) == 0);
            e  = ($urandom_range(0, 3) != 0);
            m  = 2'($urandom_range(0, 3));
            av = 8'($urandom);
            bv = 8'($urandom);
            if ($urandom_range(0, 3) == 0) bv = bv | av;
            c  = ($urandom_range(0, 15) == 0);
            modelStep(r, e, m, av, bv, c);
            applyStimulus(r, e, m, av, bv, c);
            checkOutput($sformatf("rand_%0d", i), mq, merr, mcnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
